stage_sequencer: RTL and testbench
==================================

Name: stage_sequencer

Overview:
- Multi-cycle control FSM for the TinyCPU core. It generates the `stage` value that gates the PC update logic, the register file, the ALU and the memory ports.
- Drives one instruction at a time through fetch, decode, execute, memory, writeback and PC update.
- Skips stages the current instruction type does not need.
- Holds in a stage while instruction or data memory is not ready.
- Keeps retired-instruction and stall-cycle counters for debug.

Parameters:
CNT_W, 32, width of instr_retired and stall_cycles counters

Ports:
clk  input  1  system clock
rst  input  1  synchronous active-high reset
run  input  1  level; start or resume execution from IDLE or HALTED
current_instruction_type  input  5  decoded type from instruction register; stable from DECODE through PC_UPDATE
imem_ready  input  1  instruction memory has valid data this cycle
dmem_ready  input  1  data memory access completes this cycle
stage  output  `STAGE_WIDTH (3)  current stage encoding
imem_req  output  1  instruction fetch request
dmem_req  output  1  data access request
halted  output  1  core is in HALTED
instr_retired  output  CNT_W  count of completed PC_UPDATE stages
stall_cycles  output  CNT_W  count of cycles spent waiting on memory

Behaviour:
- Clock and reset: one clock, clk, rising edge. rst is synchronous and active-high.
- Stage encodings (`STAGE_WIDTH`=3):
  - IDLE=0, IFETCH=1, DECODE=2, EXECUTE=3, MEM=4, WRITEBACK=5, PC_UPDATE=6, HALTED=7.
- Reset:
  - stage=IDLE; instr_retired=0; stall_cycles=0.
  - All of these take effect in the cycle after rst is sampled high, from any state, including mid-stall.
  - Reset has priority over every other event.
- Outputs are Moore, decoded from stage only:
  - imem_req = (stage==IFETCH)
  - dmem_req = (stage==MEM)
  - halted = (stage==HALTED)
- State transitions, one per clk:
  - IDLE: run=1 -> IFETCH; otherwise hold.
  - IFETCH: imem_ready=1 -> DECODE; otherwise hold. imem_ready in the first IFETCH cycle gives a 1-cycle fetch.
  - DECODE:
    - type==INSTR_HALT -> HALTED.
    - otherwise -> EXECUTE.
  - EXECUTE (always 1 cycle):
    - INSTR_LOAD or INSTR_STORE -> MEM.
    - INSTR_ALU -> WRITEBACK.
    - INSTR_JUMP, INSTR_NOP or any unlisted code -> PC_UPDATE.
  - MEM: hold until dmem_ready=1, then:
    - INSTR_LOAD -> WRITEBACK.
    - otherwise -> PC_UPDATE.
  - WRITEBACK (1 cycle) -> PC_UPDATE.
  - PC_UPDATE (1 cycle) -> IFETCH. instr_retired increments on this edge.
  - HALTED: run=1 -> IFETCH; otherwise hold. HALT itself does not retire.
- run is ignored in every state other than IDLE and HALTED; deasserting run mid-instruction does not stop the instruction.
- Minimum latencies, with zero-wait memory:
  - NOP/JUMP: 4 cycles (IFETCH, DECODE, EXECUTE, PC_UPDATE).
  - ALU: 5 cycles.
  - STORE: 5 cycles.
  - LOAD: 6 cycles.
- stall_cycles increments on every cycle with (stage==IFETCH && !imem_ready) or (stage==MEM && !dmem_ready).
- Both counters wrap modulo 2^CNT_W and never saturate.
- imem_ready outside IFETCH and dmem_ready outside MEM are ignored and do not advance state.
- The sequencer does not assert pc_en. The PC control logic derives pc_en from stage==PC_UPDATE, so exactly one PC write occurs per retired instruction.

Decomposition:
- Shared package (arch_defines.v): `STAGE_WIDTH` and all STAGE_* encodings, including the new IDLE and HALTED codes, plus the INSTR_* type codes, including INSTR_HALT and INSTR_NOP.
- One sub-module is natural: perf_counters, holding the two CNT_W counters with increment enables from the FSM.

Test Plan:
1. Reset, then run=1 with an ALU instruction and both memory readies tied to 1 -> stage sequence 1,2,3,5,6,1; instr_retired=1 after 5 cycles; stall_cycles=0.
2. LOAD with dmem_ready low for 3 MEM cycles -> MEM held 4 cycles, then 5 then 6; dmem_req=1 for exactly 4 cycles; stall_cycles=3.
3. IFETCH with imem_ready low for 2 cycles, then a JUMP -> stages 1,1,1,2,3,6; stall_cycles=2; stage never equals 4 or 5.
4. HALT decoded -> stage=7 and halted=1 from the next cycle; instr_retired unchanged; run pulse -> IFETCH next cycle.
5. rst asserted during MEM while dmem_ready=0 -> next cycle stage=0 and both counters 0; run low keeps IDLE.
6. Preload instr_retired to 0xFFFFFFFF via 2^32-1 forced retirements, or a reduced CNT_W=4 build with 15 retirements -> the next PC_UPDATE wraps the count to 0.

Source files
------------

// File: rtl/stage_sequencer_pkg.sv
// Shared stage and instruction-type encodings for the TinyCPU multi-cycle sequencer.
package stage_sequencer_pkg;

    localparam int STAGE_WIDTH = 3;
    localparam int ITYPE_W     = 5;

    typedef enum logic [STAGE_WIDTH-1:0] {
        STAGE_IDLE      = 3'd0,
        STAGE_IFETCH    = 3'd1,
        STAGE_DECODE    = 3'd2,
        STAGE_EXECUTE   = 3'd3,
        STAGE_MEM       = 3'd4,
        STAGE_WRITEBACK = 3'd5,
        STAGE_PC_UPDATE = 3'd6,
        STAGE_HALTED    = 3'd7
    } stage_e;

    localparam logic [ITYPE_W-1:0] INSTR_NOP   = 5'd0;
    localparam logic [ITYPE_W-1:0] INSTR_ALU   = 5'd1;
    localparam logic [ITYPE_W-1:0] INSTR_LOAD  = 5'd2;
    localparam logic [ITYPE_W-1:0] INSTR_STORE = 5'd3;
    localparam logic [ITYPE_W-1:0] INSTR_JUMP  = 5'd4;
    localparam logic [ITYPE_W-1:0] INSTR_HALT  = 5'd5;

endpackage

// File: rtl/stage_sequencer_perf_counters.sv
// Free-running debug counters for retired instructions and memory stall cycles; both wrap.
module stage_sequencer_perf_counters #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             retire_en,
    input  logic             stall_en,
    output logic [CNT_W-1:0] instr_retired,
    output logic [CNT_W-1:0] stall_cycles
);

    localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] retired_d, retired_q;
    logic [CNT_W-1:0] stall_d, stall_q;

    // Next-count computation for both counters.
    always_comb begin
        retired_d = retired_q;
        stall_d   = stall_q;
        if (retire_en) begin
            retired_d = retired_q + ONE;
        end else begin
            retired_d = retired_q;
        end
        if (stall_en) begin
            stall_d = stall_q + ONE;
        end else begin
            stall_d = stall_q;
        end
    end

    // Counter registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            retired_q <= {CNT_W{1'b0}};
            stall_q   <= {CNT_W{1'b0}};
        end else begin
            retired_q <= retired_d;
            stall_q   <= stall_d;
        end
    end

    assign instr_retired = retired_q;
    assign stall_cycles  = stall_q;

endmodule

// File: rtl/stage_sequencer.sv
// Multi-cycle stage FSM for TinyCPU: walks each instruction through only the stages it needs.
module stage_sequencer
    import stage_sequencer_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   run,
    input  logic [ITYPE_W-1:0]     current_instruction_type,
    input  logic                   imem_ready,
    input  logic                   dmem_ready,
    output logic [STAGE_WIDTH-1:0] stage,
    output logic                   imem_req,
    output logic                   dmem_req,
    output logic                   halted,
    output logic [CNT_W-1:0]       instr_retired,
    output logic [CNT_W-1:0]       stall_cycles
);

    stage_e stage_d, stage_q;
    logic   imem_req_d, imem_req_q;
    logic   dmem_req_d, dmem_req_q;
    logic   halted_d, halted_q;
    logic   retire_en_s;
    logic   stall_en_s;

    // Next-stage selection; request flags are decoded from the next stage so they stay registered.
    always_comb begin
        stage_d     = stage_q;
        retire_en_s = 1'b0;
        stall_en_s  = 1'b0;
        case (stage_q)
            STAGE_IDLE, STAGE_HALTED: begin
                if (run) begin
                    stage_d = STAGE_IFETCH;
                end else begin
                    stage_d = stage_q;
                end
            end
            STAGE_IFETCH: begin
                if (imem_ready) begin
                    stage_d = STAGE_DECODE;
                end else begin
                    stage_d    = STAGE_IFETCH;
                    stall_en_s = 1'b1;
                end
            end
            STAGE_DECODE: begin
                if (current_instruction_type == INSTR_HALT) begin
                    stage_d = STAGE_HALTED;
                end else begin
                    stage_d = STAGE_EXECUTE;
                end
            end
            STAGE_EXECUTE: begin
                case (current_instruction_type)
                    INSTR_LOAD, INSTR_STORE: stage_d = STAGE_MEM;
                    INSTR_ALU:               stage_d = STAGE_WRITEBACK;
                    default:                 stage_d = STAGE_PC_UPDATE;
                endcase
            end
            STAGE_MEM: begin
                if (!dmem_ready) begin
                    stage_d    = STAGE_MEM;
                    stall_en_s = 1'b1;
                end else if (current_instruction_type == INSTR_LOAD) begin
                    stage_d = STAGE_WRITEBACK;
                end else begin
                    stage_d = STAGE_PC_UPDATE;
                end
            end
            STAGE_WRITEBACK: stage_d = STAGE_PC_UPDATE;
            STAGE_PC_UPDATE: begin
                stage_d     = STAGE_IFETCH;
                retire_en_s = 1'b1;
            end
            default: stage_d = STAGE_IDLE;
        endcase
        imem_req_d = (stage_d == STAGE_IFETCH);
        dmem_req_d = (stage_d == STAGE_MEM);
        halted_d   = (stage_d == STAGE_HALTED);
    end

    // Stage and decoded-output registers; reset wins over everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            stage_q    <= STAGE_IDLE;
            imem_req_q <= 1'b0;
            dmem_req_q <= 1'b0;
            halted_q   <= 1'b0;
        end else begin
            stage_q    <= stage_d;
            imem_req_q <= imem_req_d;
            dmem_req_q <= dmem_req_d;
            halted_q   <= halted_d;
        end
    end

    stage_sequencer_perf_counters #(.CNT_W(CNT_W)) u_perf_counters (
        .clk           (clk),
        .rst           (rst),
        .retire_en     (retire_en_s),
        .stall_en      (stall_en_s),
        .instr_retired (instr_retired),
        .stall_cycles  (stall_cycles)
    );

    assign stage    = stage_q;
    assign imem_req = imem_req_q;
    assign dmem_req = dmem_req_q;
    assign halted   = halted_q;

endmodule

// File: tb/tb_stage_sequencer.sv
// Directed bench for stage_sequencer; a second CNT_W=4 instance shares the stimulus to reach counter wrap.
module tb_stage_sequencer;
    import stage_sequencer_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        run;
    logic [4:0]  itype;
    logic        imem_ready;
    logic        dmem_ready;

    logic [2:0]  stage;
    logic        imem_req, dmem_req, halted;
    logic [31:0] instr_retired, stall_cycles;

    logic [2:0]  stage4;
    logic        imem_req4, dmem_req4, halted4;
    logic [3:0]  instr_retired4, stall_cycles4;

    int cmp_cnt = 0;
    int fail_cnt = 0;

    always #5 clk = ~clk;

    stage_sequencer #(.CNT_W(32)) dut (
        .clk(clk), .rst(rst), .run(run), .current_instruction_type(itype),
        .imem_ready(imem_ready), .dmem_ready(dmem_ready), .stage(stage),
        .imem_req(imem_req), .dmem_req(dmem_req), .halted(halted),
        .instr_retired(instr_retired), .stall_cycles(stall_cycles)
    );

    stage_sequencer #(.CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .run(run), .current_instruction_type(itype),
        .imem_ready(imem_ready), .dmem_ready(dmem_ready), .stage(stage4),
        .imem_req(imem_req4), .dmem_req(dmem_req4), .halted(halted4),
        .instr_retired(instr_retired4), .stall_cycles(stall_cycles4)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        cmp_cnt++;
        assert (obs === exp) else begin
            fail_cnt++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_stage(input string tag, input logic [2:0] exp);
        chk({tag, ".stage"}, {29'd0, stage}, {29'd0, exp});
        chk({tag, ".imem_req"}, {31'd0, imem_req}, {31'd0, exp == 3'd1});
        chk({tag, ".dmem_req"}, {31'd0, dmem_req}, {31'd0, exp == 3'd4});
        chk({tag, ".halted"}, {31'd0, halted}, {31'd0, exp == 3'd7});
    endtask

    initial begin
        rst = 1'b1; run = 1'b0; itype = INSTR_ALU; imem_ready = 1'b1; dmem_ready = 1'b1;
        step(); step();
        chk_stage("rst", 3'd0);
        chk("rst.retired", instr_retired, 32'd0);
        chk("rst.stall", stall_cycles, 32'd0);
        rst = 1'b0;

        // ALU instruction, zero-wait memory: 1,2,3,5,6,1
        run = 1'b1;
        step(); chk_stage("alu.if", 3'd1);
        run = 1'b0;
        step(); chk_stage("alu.dec", 3'd2);
        step(); chk_stage("alu.ex", 3'd3);
        step(); chk_stage("alu.wb", 3'd5);
        step(); chk_stage("alu.pc", 3'd6);
        chk("alu.retired_pre", instr_retired, 32'd0);
        step(); chk_stage("alu.if2", 3'd1);
        chk("alu.retired", instr_retired, 32'd1);
        chk("alu.stall", stall_cycles, 32'd0);

        // LOAD with three data-memory wait cycles
        itype = INSTR_LOAD; dmem_ready = 1'b0;
        step(); chk_stage("ld.dec", 3'd2);
        step(); chk_stage("ld.ex", 3'd3);
        step(); chk_stage("ld.mem0", 3'd4);
        chk("ld.stall0", stall_cycles, 32'd0);
        step(); chk_stage("ld.mem1", 3'd4);
        step(); chk_stage("ld.mem2", 3'd4);
        step(); chk_stage("ld.mem3", 3'd4);
        chk("ld.stall3", stall_cycles, 32'd3);
        dmem_ready = 1'b1;
        step(); chk_stage("ld.wb", 3'd5);
        chk("ld.stall", stall_cycles, 32'd3);
        step(); chk_stage("ld.pc", 3'd6);
        step(); chk_stage("ld.if", 3'd1);
        chk("ld.retired", instr_retired, 32'd2);

        // JUMP with two instruction-memory wait cycles
        itype = INSTR_JUMP; imem_ready = 1'b0;
        step(); chk_stage("jmp.if1", 3'd1);
        step(); chk_stage("jmp.if2", 3'd1);
        imem_ready = 1'b1;
        step(); chk_stage("jmp.dec", 3'd2);
        step(); chk_stage("jmp.ex", 3'd3);
        step(); chk_stage("jmp.pc", 3'd6);
        step(); chk_stage("jmp.if", 3'd1);
        chk("jmp.stall", stall_cycles, 32'd5);
        chk("jmp.retired", instr_retired, 32'd3);

        // HALT: parks in HALTED without retiring, run resumes to IFETCH
        itype = INSTR_HALT;
        step(); chk_stage("hlt.dec", 3'd2);
        step(); chk_stage("hlt.halt", 3'd7);
        step(); chk_stage("hlt.hold", 3'd7);
        chk("hlt.retired", instr_retired, 32'd3);
        run = 1'b1;
        step(); chk_stage("hlt.resume", 3'd1);
        run = 1'b0;

        // Reset during a stalled STORE in MEM
        itype = INSTR_STORE; dmem_ready = 1'b0;
        step(); chk_stage("st.dec", 3'd2);
        step(); chk_stage("st.ex", 3'd3);
        step(); chk_stage("st.mem", 3'd4);
        step(); chk_stage("st.mem1", 3'd4);
        chk("st.stall", stall_cycles, 32'd6);
        rst = 1'b1;
        step(); chk_stage("st.rst", 3'd0);
        chk("st.rst.retired", instr_retired, 32'd0);
        chk("st.rst.stall", stall_cycles, 32'd0);
        chk("st.rst.retired4", {28'd0, instr_retired4}, 32'd0);
        rst = 1'b0; dmem_ready = 1'b1;
        step(); chk_stage("st.idle", 3'd0);
        step(); chk_stage("st.idle2", 3'd0);

        // NOPs to wrap the 4-bit retired counter
        itype = INSTR_NOP; run = 1'b1;
        step(); chk_stage("nop.if", 3'd1);
        run = 1'b0;
        for (int i = 1; i <= 16; i++) begin
            step(); step(); step();
            chk($sformatf("nop%0d.pc", i), {29'd0, stage}, 32'd6);
            step();
            chk($sformatf("nop%0d.if", i), {29'd0, stage}, 32'd1);
            chk($sformatf("nop%0d.retired", i), instr_retired, i);
            chk($sformatf("nop%0d.retired4", i), {28'd0, instr_retired4}, i % 16);
        end
        chk("nop.stall", stall_cycles, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, fail_cnt);
        $finish;
    end

endmodule
